mem_bus_arbiter: RTL and testbench

Arbitrates the shared memory bus between two masters: the debug probe (master P) and the unicycle CPU data port (master C). Sits between the master-side MemoryBus::Cmd/Result pairs and the slave bus mux, and is a drop-in replacement for the static probe/CPU select. Adds request/grant handshaking, a one-cycle turnaround on ownership change, probe bus locking and CPU starvation protection. Read-data return is tagged to the issuing master.

---
 rtl/mem_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master memory bus arbiter: the debug probe (P) and the CPU data port (C)
// share one slave bus. Ownership changes through a one-cycle turnaround.

package MemoryBus;
  typedef struct packed {
    logic [29:0] address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mask_byte;
    logic [31:0] write_data;
  } Cmd;
endpackage

module mem_bus_arbiter #(
  parameter int READ_LATENCY   = 1,
  parameter int MAX_PROBE_HOLD = 16,
  parameter int HOLD_W         = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_lock,
  input  MemoryBus::Cmd p_cmd,
  output logic          p_gnt,
  output logic [31:0]   p_rdata,
  output logic          p_rvalid,
  input  logic          c_req,
  input  MemoryBus::Cmd c_cmd,
  output logic          c_stall,
  output logic [31:0]   c_rdata,
  output logic          c_rvalid,
  output MemoryBus::Cmd bus_cmd,
  input  logic [31:0]   bus_rdata,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    CPU_OWN   = 2'b01,
    PROBE_OWN = 2'b10,
    TURN      = 2'b11
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_PROBE_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  state_e            state_q, state_d;
  logic              target_p_q, target_p_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_tag_p_q, rd_tag_p_d;

  logic [HOLD_W-1:0] hold_inc;
  logic              hold_limit;
  logic              p_want;
  logic              c_rd_acc, p_rd_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CPU_OWN;
      target_p_q <= 1'b0;
      hold_q     <= '0;
      rd_vld_q   <= 1'b0;
      rd_tag_p_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_p_q <= target_p_d;
      hold_q     <= hold_d;
      rd_vld_q   <= rd_vld_d;
      rd_tag_p_q <= rd_tag_p_d;
    end
  end

  // The limit fires on the cycle whose increment reaches MAX_PROBE_HOLD, so the
  // probe gets exactly MAX_PROBE_HOLD cycles while the CPU waits.
  always_comb begin
    p_want     = p_req | p_lock;
    hold_inc   = (c_req && hold_q != HOLD_SAT) ? hold_q + HOLD_W'(1) : hold_q;
    hold_limit = (MAX_PROBE_HOLD != 0) && c_req && (hold_inc == HOLD_MAX);

    state_d    = state_q;
    target_p_d = target_p_q;
    hold_d     = hold_q;
    case (state_q)
      IDLE: begin
        if (p_req) begin
          state_d    = TURN;
          target_p_d = 1'b1;
        end else if (c_req) begin
          state_d = CPU_OWN;
        end
      end
      CPU_OWN: begin
        if (p_req) begin
          state_d    = TURN;
          target_p_d = 1'b1;
        end
      end
      PROBE_OWN: begin
        hold_d = hold_inc;
        if (!p_want || hold_limit) begin
          if (c_req) begin
            state_d    = TURN;
            target_p_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TURN: begin
        if (!target_p_q)  state_d = CPU_OWN;
        else if (p_want)  state_d = PROBE_OWN;
        else              state_d = IDLE;
      end
      default: state_d = CPU_OWN;
    endcase
    if (state_d == PROBE_OWN && state_q != PROBE_OWN) hold_d = '0;
  end

  // Reads with both mem_read and mem_write set are left to the slave and never return data.
  always_comb begin
    c_rd_acc   = (state_q == CPU_OWN) && c_cmd.mem_read && !c_cmd.mem_write;
    p_rd_acc   = (state_q == PROBE_OWN) && p_cmd.mem_read && !p_cmd.mem_write;
    rd_vld_d   = c_rd_acc | p_rd_acc;
    rd_tag_p_d = p_rd_acc;
  end

  always_comb begin
    owner    = state_q;
    bus_cmd  = '0;
    p_gnt    = 1'b0;
    c_stall  = 1'b0;
    p_rvalid = 1'b0;
    c_rvalid = 1'b0;
    p_rdata  = '0;
    c_rdata  = '0;
    if (rst) begin
      if (state_q == CPU_OWN)   bus_cmd = c_cmd;
      if (state_q == PROBE_OWN) bus_cmd = p_cmd;
      p_gnt   = (state_q == PROBE_OWN);
      c_stall = c_req && (state_q != CPU_OWN);
      if (READ_LATENCY == 0) begin
        p_rvalid = p_rd_acc;
        c_rvalid = c_rd_acc;
      end else begin
        p_rvalid = rd_vld_q && rd_tag_p_q;
        c_rvalid = rd_vld_q && !rd_tag_p_q;
      end
      // Unselected master sees zero so the other master's data never leaks.
      p_rdata = p_rvalid ? bus_rdata : '0;
      c_rdata = c_rvalid ? bus_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a word-level memory slave, an ownership
// model built from the arbitration rules, and directed literal checks.

module tb_mem_bus_arbiter;

  localparam int LAT  = 1;
  localparam int MAXH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p_req, p_lock, p_gnt, p_rvalid;
  MemoryBus::Cmd p_cmd;
  logic [31:0]   p_rdata;
  logic          c_req, c_stall, c_rvalid;
  MemoryBus::Cmd c_cmd;
  logic [31:0]   c_rdata;
  MemoryBus::Cmd bus_cmd;
  logic [31:0]   bus_rdata;
  logic [1:0]    owner;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_bus_arbiter #(
    .READ_LATENCY(LAT), .MAX_PROBE_HOLD(MAXH), .HOLD_W(5)
  ) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_lock(p_lock), .p_cmd(p_cmd), .p_gnt(p_gnt),
    .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .c_req(c_req), .c_cmd(c_cmd), .c_stall(c_stall),
    .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .bus_cmd(bus_cmd), .bus_rdata(bus_rdata), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic MemoryBus::Cmd mk_cmd(input bit rd, input bit wr, input int addr,
                                           input logic [3:0] mask, input logic [31:0] data);
    MemoryBus::Cmd c;
    c            = '0;
    c.address    = 30'(addr);
    c.mem_read   = rd;
    c.mem_write  = wr;
    c.mask_byte  = mask;
    c.write_data = data;
    return c;
  endfunction

  function automatic MemoryBus::Cmd rand_cmd();
    int k;
    k = int'($urandom_range(0, 9));
    return mk_cmd(k < 4 || k == 9, k >= 4, int'($urandom_range(0, 63)),
                  4'($urandom), $urandom);
  endfunction

  // Memory slave: one-cycle read latency, junk on bus_rdata when no read returns.
  logic [31:0] slave_mem [64];
  logic [31:0] slave_word;
  always @(posedge clk) begin
    bus_rdata <= $urandom;
    if (bus_cmd.mem_read && !bus_cmd.mem_write) bus_rdata <= slave_mem[bus_cmd.address[5:0]];
    if (bus_cmd.mem_write) begin
      slave_word = slave_mem[bus_cmd.address[5:0]];
      for (int b = 0; b < 4; b++)
        if (bus_cmd.mask_byte[b]) slave_word[8*b +: 8] = bus_cmd.write_data[8*b +: 8];
      slave_mem[bus_cmd.address[5:0]] <= slave_word;
    end
  end

  // Reference model: m_owner is 0 none, 1 CPU, 2 probe, 3 turnaround.
  int            m_owner, m_next, m_starve;
  bit            m_target_p, m_pend, m_pend_p, cpu_done;
  logic [31:0]   m_pend_data, m_word;
  logic [31:0]   shadow [64];
  MemoryBus::Cmd m_cmd;

  function automatic MemoryBus::Cmd model_bus();
    if (m_owner == 1) return c_cmd;
    if (m_owner == 2) return p_cmd;
    return '0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 1; m_target_p = 0; m_starve = 0; m_pend = 0; m_pend_p = 0; cpu_done = 0;
    end else begin
      m_cmd    = model_bus();
      cpu_done = (m_owner == 1) && c_req;
      m_pend   = m_cmd.mem_read && !m_cmd.mem_write;
      m_pend_p = (m_owner == 2);
      if (m_pend) m_pend_data = shadow[m_cmd.address[5:0]];
      if (m_cmd.mem_write) begin
        m_word = shadow[m_cmd.address[5:0]];
        for (int b = 0; b < 4; b++)
          if (m_cmd.mask_byte[b]) m_word[8*b +: 8] = m_cmd.write_data[8*b +: 8];
        shadow[m_cmd.address[5:0]] = m_word;
      end
      m_next = m_owner;
      case (m_owner)
        0: if (p_req) begin m_next = 3; m_target_p = 1; end
           else if (c_req) m_next = 1;
        1: if (p_req) begin m_next = 3; m_target_p = 1; end
        2: begin
          if (c_req) m_starve++;
          if (!(p_req || p_lock) || (MAXH != 0 && m_starve >= MAXH)) begin
            if (c_req) begin m_next = 3; m_target_p = 0; end
            else m_next = 0;
          end
        end
        default: m_next = !m_target_p ? 1 : ((p_req || p_lock) ? 2 : 0);
      endcase
      if (m_next == 2 && m_owner != 2) m_starve = 0;
      m_owner = m_next;
    end
  end

  MemoryBus::Cmd e_bus;
  logic [31:0]   e_own;
  logic          e_pg, e_cs, e_pv, e_cv;
  always @(negedge clk) begin
    e_bus = '0; e_own = 32'd1; e_pg = 0; e_cs = 0; e_pv = 0; e_cv = 0;
    if (rst) begin
      e_bus = model_bus();
      e_own = 32'(m_owner);
      e_pg  = (m_owner == 2);
      e_cs  = c_req && (m_owner != 1);
      e_pv  = m_pend && m_pend_p;
      e_cv  = m_pend && !m_pend_p;
    end
    checkOutput("owner",    32'(owner),                 e_own);
    checkOutput("p_gnt",    32'(p_gnt),                 32'(e_pg));
    checkOutput("c_stall",  32'(c_stall),               32'(e_cs));
    checkOutput("bus_addr", 32'(bus_cmd.address),       32'(e_bus.address));
    checkOutput("bus_ctl",  {26'd0, bus_cmd.mem_read, bus_cmd.mem_write, bus_cmd.mask_byte},
                            {26'd0, e_bus.mem_read, e_bus.mem_write, e_bus.mask_byte});
    checkOutput("bus_wdat", bus_cmd.write_data,         e_bus.write_data);
    checkOutput("p_rvalid", 32'(p_rvalid),              32'(e_pv));
    checkOutput("p_rdata",  p_rdata,                    e_pv ? m_pend_data : 32'd0);
    checkOutput("c_rvalid", 32'(c_rvalid),              32'(e_cv));
    checkOutput("c_rdata",  c_rdata,                    e_cv ? m_pend_data : 32'd0);
  end

  // One bus cycle of stimulus; hold_cpu keeps a stalled CPU command in place.
  task automatic applyStimulus(input bit pr, input bit pl, input MemoryBus::Cmd pc,
                               input MemoryBus::Cmd cc, input bit hold_cpu);
    @(posedge clk);
    #1;
    p_req  = pr;
    p_lock = pl;
    p_cmd  = pc;
    if (!(hold_cpu && c_req && !cpu_done)) c_cmd = cc;
    c_req = c_cmd.mem_read | c_cmd.mem_write;
  endtask

  MemoryBus::Cmd nop;
  int            own_log [36];
  bit            stall_log [36];
  int            run_len;
  bit            reached;

  initial begin
    for (int i = 0; i < 64; i++) begin
      slave_mem[i] = mem_init(i);
      shadow[i]    = mem_init(i);
    end
    nop    = '0;
    p_req  = 0; p_lock = 0; p_cmd = nop;
    c_cmd  = mk_cmd(1, 0, 'h10, 4'h0, 32'h0);
    c_req  = 1;
    #22 rst = 1;
    #1;
    checkOutput("boot_owner", 32'(owner), 32'd1);
    checkOutput("boot_stall", 32'(c_stall), 32'd0);
    @(negedge clk);
    checkOutput("boot_c_rvalid", 32'(c_rvalid), 32'd1);
    checkOutput("boot_c_rdata", c_rdata, 32'hC0DE_0010);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, nop, mk_cmd(1, 0, 'h11 + i, 0, 0), 0);
    applyStimulus(1, 0, nop, mk_cmd(1, 0, 'h14, 0, 0), 0);
    @(negedge clk);
    checkOutput("take_owner_cpu", 32'(owner), 32'd1);
    checkOutput("take_stall0", 32'(c_stall), 32'd0);
    applyStimulus(1, 0, nop, mk_cmd(1, 0, 'h15, 0, 0), 0);
    @(negedge clk);
    checkOutput("take_owner_turn", 32'(owner), 32'd3);
    checkOutput("take_bus_rd", 32'(bus_cmd.mem_read), 32'd0);
    checkOutput("take_stall1", 32'(c_stall), 32'd1);
    checkOutput("take_c_rdata", c_rdata, 32'hC0DE_0014);
    applyStimulus(1, 0, nop, mk_cmd(1, 0, 'h15, 0, 0), 0);
    @(negedge clk);
    checkOutput("take_p_gnt", 32'(p_gnt), 32'd1);
    checkOutput("take_stall2", 32'(c_stall), 32'd1);

    applyStimulus(1, 0, mk_cmd(0, 1, 'h20, 4'hF, 32'hDEAD_BEEF), nop, 0);
    applyStimulus(1, 0, mk_cmd(1, 0, 'h20, 4'h0, 32'h0), nop, 0);
    applyStimulus(1, 0, nop, nop, 0);
    @(negedge clk);
    checkOutput("wb_p_rvalid", 32'(p_rvalid), 32'd1);
    checkOutput("wb_p_rdata", p_rdata, 32'hDEAD_BEEF);
    checkOutput("wb_c_rvalid", 32'(c_rvalid), 32'd0);

    applyStimulus(0, 0, nop, nop, 0);
    applyStimulus(0, 0, nop, nop, 0);
    @(negedge clk);
    checkOutput("rel_idle", 32'(owner), 32'd0);
    applyStimulus(0, 0, nop, mk_cmd(1, 0, 'h22, 0, 0), 0);
    @(negedge clk);
    checkOutput("rel_idle_stall", 32'(c_stall), 32'd1);
    applyStimulus(0, 0, nop, mk_cmd(1, 0, 'h22, 0, 0), 0);
    @(negedge clk);
    checkOutput("rel_cpu_owner", 32'(owner), 32'd1);
    checkOutput("rel_cpu_stall", 32'(c_stall), 32'd0);

    reached = 0;
    for (int i = 0; i < 8 && !reached; i++) begin
      applyStimulus(1, 1, nop, nop, 0);
      @(negedge clk);
      reached = (owner == 2'b10);
    end
    checkOutput("starve_setup", 32'(reached), 32'd1);
    for (int i = 0; i < 36; i++) begin
      applyStimulus(1, 1, nop, mk_cmd(1, 0, 'h21, 0, 0), 0);
      @(negedge clk);
      own_log[i]   = int'(owner);
      stall_log[i] = c_stall;
    end
    run_len = 0;
    while (run_len < 36 && own_log[run_len] == 2) run_len++;
    checkOutput("starve_run1", 32'(run_len), 32'd16);
    checkOutput("starve_turn1", 32'(own_log[16]), 32'd3);
    checkOutput("starve_cpu", 32'(own_log[17]), 32'd1);
    checkOutput("starve_cpu_stall", 32'(stall_log[17]), 32'd0);
    checkOutput("starve_turn2", 32'(own_log[18]), 32'd3);
    run_len = 0;
    while (19 + run_len < 36 && own_log[19 + run_len] == 2) run_len++;
    checkOutput("starve_run2", 32'(run_len), 32'd16);
    checkOutput("starve_turn3", 32'(own_log[35]), 32'd3);

    reached = 0;
    for (int i = 0; i < 8 && !reached; i++) begin
      applyStimulus(1, 0, nop, nop, 0);
      @(negedge clk);
      reached = (owner == 2'b10);
    end
    checkOutput("rst_setup", 32'(reached), 32'd1);
    applyStimulus(1, 0, mk_cmd(1, 0, 'h20, 0, 0), nop, 0);
    @(posedge clk);
    #2 rst = 0;
    #1;
    checkOutput("rst_p_rvalid", 32'(p_rvalid), 32'd0);
    checkOutput("rst_p_gnt", 32'(p_gnt), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd1);
    checkOutput("rst_bus_rd", 32'(bus_cmd.mem_read), 32'd0);
    @(negedge clk);
    #1;
    p_req = 0; p_cmd = nop;
    #2 rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("rst_post_rvalid", 32'(p_rvalid), 32'd0);
      checkOutput("rst_post_owner", 32'(owner), 32'd1);
    end

    for (int n = 0; n < 3000; n++)
      applyStimulus(($urandom % 3) == 0, ($urandom % 5) == 0, rand_cmd(),
                    ($urandom % 2) ? rand_cmd() : nop, 1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
